dp_axil_csr: RTL and testbench



---
 rtl/dp_axil_csr.sv | 155 +++++++++++++++
 tb/tb_dp_axil_csr.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_axil_csr.sv
// dp_axil_csr: AXI-Lite CSR file holding Data Plane control fields, status readback and a W1C interrupt.
module dp_axil_csr #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    input  logic [15:0]           status_in,
    input  logic                  event_in,
    output logic                  ctrl_enable,
    output logic [3:0]            ctrl_mode,
    output logic                  irq
);
    typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [2:0] aw_q, waddr;
    logic [DATA_WIDTH-1:0] wd_q, wd, scratch, wr_count, rd_val;
    logic [3:0] ws_q, ws;
    logic aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok, irq_pend, irq_clr;
    logic unused_addr;

    assign aw_hs = awvalid & awready;
    assign w_hs = wvalid & wready;
    assign ar_hs = arvalid & arready;
    // Whichever half arrives in the commit cycle is taken live, the other from its holding register.
    assign waddr = aw_hs ? awaddr[4:2] : aw_q;
    assign wd = w_hs ? wdata : wd_q;
    assign ws = w_hs ? wstrb : ws_q;
    assign commit = (w_next == W_RESP) && (w_state != W_RESP);
    assign wr_ok = (waddr == 3'd0) || (waddr == 3'd2) || (waddr == 3'd4);
    assign irq_clr = commit && (waddr == 3'd4) && wd[0];
    assign irq = irq_pend;
    assign unused_addr = ^{awaddr[ADDR_WIDTH-1:5], awaddr[1:0], araddr[ADDR_WIDTH-1:5], araddr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        awready = 1'b0;
        wready = 1'b0;
        bvalid = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                wready = 1'b1;
                w_next = (awvalid && wvalid) ? W_RESP : awvalid ? W_GOT_AW : wvalid ? W_GOT_W : W_IDLE;
            end
            W_GOT_AW: begin
                wready = 1'b1;
                w_next = wvalid ? W_RESP : W_GOT_AW;
            end
            W_GOT_W: begin
                awready = 1'b1;
                w_next = awvalid ? W_RESP : W_GOT_W;
            end
            default: begin
                bvalid = 1'b1;
                w_next = bready ? W_IDLE : W_RESP;
            end
        endcase
    end

    always_comb begin
        arready = (r_state == R_IDLE);
        rvalid = (r_state == R_DATA);
        r_next = (r_state == R_IDLE) ? (arvalid ? R_DATA : R_IDLE) : (rready ? R_IDLE : R_DATA);
    end

    always_comb begin
        rd_ok = 1'b1;
        rd_val = '0;
        case (araddr[4:2])
            3'd0: rd_val = {24'h0, ctrl_mode, 3'b000, ctrl_enable};
            3'd1: rd_val = {16'h0, status_in};
            3'd2: rd_val = scratch;
            3'd3: rd_val = wr_count;
            3'd4: rd_val = {31'h0, irq_pend};
            default: rd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_q <= '0;
            wd_q <= '0;
            ws_q <= '0;
            bresp <= 2'b00;
            wr_count <= '0;
            ctrl_enable <= 1'b0;
            ctrl_mode <= '0;
            scratch <= '0;
            irq_pend <= 1'b0;
        end else begin
            if (aw_hs)
                aw_q <= awaddr[4:2];
            if (w_hs) begin
                wd_q <= wdata;
                ws_q <= wstrb;
            end
            if (commit) begin
                bresp <= wr_ok ? 2'b00 : 2'b10;
                if (wr_ok)
                    wr_count <= wr_count + 1;
            end
            if (commit && waddr == 3'd0 && ws[0]) begin
                ctrl_enable <= wd[0];
                ctrl_mode <= wd[7:4];
            end
            if (commit && waddr == 3'd2)
                for (int i = 0; i < 4; i++)
                    if (ws[i])
                        scratch[8*i +: 8] <= wd[8*i +: 8];
            // A new event outranks a simultaneous W1C clear.
            irq_pend <= event_in | (irq_pend & ~irq_clr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
            rresp <= 2'b00;
        end else if (ar_hs) begin
            rdata <= rd_val;
            rresp <= rd_ok ? 2'b00 : 2'b10;
        end
    end
endmodule

// File: tb/tb_dp_axil_csr.sv
// tb_dp_axil_csr: directed plus randomized checks of dp_axil_csr against a register-level model.
module tb_dp_axil_csr;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, event_in = 0;
    logic awready, wready, bvalid, arready, rvalid, ctrl_enable, irq;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
    logic [3:0] wstrb = 0, ctrl_mode;
    logic [1:0] bresp, rresp;
    logic [15:0] status_in = 0;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_ctrl, m_scratch, m_count;
    logic m_irq;

    dp_axil_csr dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .status_in(status_in), .event_in(event_in),
        .ctrl_enable(ctrl_enable), .ctrl_mode(ctrl_mode), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ctrl = 0;
        m_scratch = 0;
        m_count = 0;
        m_irq = 0;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ev);
        logic [31:0] merged;
        logic ok;
        int off;
        off = int'(a & 32'h1C);
        ok = (off == 'h00) || (off == 'h08) || (off == 'h10);
        merged = (off == 'h00) ? m_ctrl : m_scratch;
        for (int b = 0; b < 4; b++)
            if (s[b]) merged[8*b +: 8] = d[8*b +: 8];
        if (off == 'h00) m_ctrl = merged & 32'h0000_00F1;
        if (off == 'h08) m_scratch = merged;
        if (off == 'h10 && d[0]) m_irq = 0;
        if (ev) m_irq = 1;
        if (ok) m_count = m_count + 1;
        return ok ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a, input logic [15:0] st);
        int off;
        off = int'(a & 32'h1C);
        if (off == 'h00) return {2'b00, m_ctrl};
        if (off == 'h04) return {2'b00, 16'h0, st};
        if (off == 'h08) return {2'b00, m_scratch};
        if (off == 'h0C) return {2'b00, m_count};
        if (off == 'h10) return {2'b00, 31'h0, m_irq};
        return {2'b10, 32'h0};
    endfunction

    // order: 0 = AW and W together, 1 = W first, 2 = AW first
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int order, input logic ev);
        logic [1:0] er;
        er = model_write(a, d, s, ev);
        @(negedge clk);
        awaddr = a;
        wdata = d;
        wstrb = s;
        if (order == 0) begin
            awvalid = 1;
            wvalid = 1;
            event_in = ev;
        end else begin
            if (order == 1) wvalid = 1;
            else awvalid = 1;
            @(negedge clk);
            check("bvalid_half", {31'h0, bvalid}, 32'h0);
            awvalid = (order == 1);
            wvalid = (order != 1);
            event_in = ev;
        end
        @(negedge clk);
        awvalid = 0;
        wvalid = 0;
        event_in = 0;
        check("bvalid", {31'h0, bvalid}, 32'h1);
        check("bresp", {30'h0, bresp}, {30'h0, er});
        check("ctrl_out", {27'h0, ctrl_mode, ctrl_enable}, {27'h0, m_ctrl[7:4], m_ctrl[0]});
        check("irq", {31'h0, irq}, {31'h0, m_irq});
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("bvalid_done", {30'h0, bvalid, awready}, 32'h1);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [15:0] st);
        logic [33:0] e;
        @(negedge clk);
        araddr = a;
        arvalid = 1;
        status_in = st;
        e = model_read(a, st);
        @(negedge clk);
        arvalid = 0;
        check("rvalid", {31'h0, rvalid}, 32'h1);
        check("rdata", rdata, e[31:0]);
        check("rresp", {30'h0, rresp}, {30'h0, e[33:32]});
        rready = 1;
        @(negedge clk);
        rready = 0;
        check("rvalid_done", {30'h0, rvalid, arready}, 32'h1);
    endtask

    task automatic pulse_event();
        @(negedge clk);
        event_in = 1;
        m_irq = 1;
        @(negedge clk);
        event_in = 0;
        check("irq_rise", {31'h0, irq}, 32'h1);
    endtask

    initial begin
        logic [31:0] pre, held, a, d;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 0;
        check("reset_ready", {29'h0, awready, wready, arready}, 32'h7);
        check("reset_valid", {30'h0, bvalid, rvalid}, 32'h0);
        check("reset_outs", {26'h0, ctrl_mode, ctrl_enable, irq}, 32'h0);
        axi_read(32'h00, 16'h0);
        axi_read(32'h08, 16'h0);
        axi_read(32'h0C, 16'h0);
        axi_read(32'h10, 16'h0);

        axi_write(32'h08, 32'hA5A5_A5A5, 4'b0101, 1, 1'b0);
        axi_read(32'h08, 16'h0);
        check("scratch_strb", m_scratch, 32'h00A5_00A5);
        axi_read(32'h0C, 16'h0);
        axi_write(32'h00, 32'hFFFF_FFFF, 4'hF, 2, 1'b0);
        check("ctrl_en_mode", {27'h0, ctrl_mode, ctrl_enable}, 32'h1F);
        axi_read(32'h00, 16'h0);
        axi_read(32'h04, 16'hBEEF);

        pulse_event();
        axi_write(32'h10, 32'h1, 4'h0, 0, 1'b1);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        axi_write(32'h10, 32'h1, 4'h0, 0, 1'b0);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        axi_write(32'h04, 32'h1234, 4'hF, 0, 1'b0);
        axi_write(32'h14, 32'h1234, 4'hF, 1, 1'b0);
        axi_read(32'h18, 16'h0);
        axi_read(32'h0C, 16'h0);

        // Read and write of SCRATCH accepted together, then both responses stalled.
        pulse_event();
        pre = m_scratch;
        void'(model_write(32'h08, 32'h1234_5678, 4'hF, 1'b0));
        @(negedge clk);
        awaddr = 32'h08; wdata = 32'h1234_5678; wstrb = 4'hF; araddr = 32'h08;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        held = rdata;
        check("read_pre_write", held, pre);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {30'h0, bvalid, rvalid}, 32'h3);
            check("hold_rdata", rdata, held);
            check("hold_ready", {30'h0, awready, arready}, 32'h0);
            @(negedge clk);
        end
        #2 reset = 1;
        #1;
        check("async_valid", {30'h0, bvalid, rvalid}, 32'h0);
        check("async_ready", {29'h0, awready, wready, arready}, 32'h7);
        check("async_rdata", rdata, 32'h0);
        check("async_outs", {26'h0, ctrl_mode, ctrl_enable, irq}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 0;
        axi_read(32'h08, 16'h0);
        axi_read(32'h0C, 16'h0);

        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            d = $urandom;
            case ($urandom_range(0, 3))
                0, 1: axi_write(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                2: axi_read(a, 16'($urandom));
                default: pulse_event();
            endcase
        end
        axi_read(32'h0C, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
